// File: rtl/sim_top_pkg.sv
// Shared constants, types and helpers for the music player top.
// A song is ten 4-bit note codes; the MSB nibble plays first.
package sim_top_pkg;

  localparam int NUM_NOTES = 10;
  localparam int NOTE_W    = 4;
  localparam int SONG_W    = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_e;

  // Packed view of the song word: element [NUM_NOTES-1] is note 0.
  typedef logic [NUM_NOTES-1:0][NOTE_W-1:0] song_t;

  // Tone half-period in clock cycles; code 0 is a rest and never reaches the tone generator.
  function automatic int half_period(input logic [NOTE_W-1:0] code, input int unit);
    return (16 - int'(code)) * unit;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: output starts low on restart and toggles
// every half_period_i enabled cycles until the next restart.
module tone_gen #(
  parameter int HP_W = 4
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic            restart_i,
  input  logic            en_i,
  input  logic [HP_W-1:0] half_period_i,
  output logic            wave_o
);

  logic [HP_W-1:0] phase_q, phase_d;
  logic            wave_q,  wave_d;

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path can infer a latch.
    phase_d = phase_q;
    wave_d  = wave_q;
    if (restart_i) begin
      phase_d = '0;
      wave_d  = 1'b0;
    end else if (en_i) begin
      if (phase_q == half_period_i - HP_W'(1)) begin
        phase_d = '0;
        wave_d  = ~wave_q;
      end else begin
        phase_d = phase_q + HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst_i) begin
      phase_q <= '0;
      wave_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wave_q  <= wave_d;
    end
  end

  assign wave_o = wave_q;

endmodule

// File: rtl/sim_top.sv
// Music player top: latches a 40-bit song under ce, then plays its ten
// notes as a square wave on pwm while maingMusic is high.
module sim_top
  import sim_top_pkg::*;
#(
  parameter int NOTE_CYCLES      = 16,
  parameter int HALF_PERIOD_UNIT = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [SONG_W-1:0] newFlattenedMCUout,
  input  logic              ce,
  output logic              pwm,
  output logic              maingMusic
);

  localparam int CNT_W = $clog2(NOTE_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_NOTES);
  localparam int HP_W  = $clog2(15 * HALF_PERIOD_UNIT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NOTES - 1);

  state_e           state_q, state_d;
  song_t            song_q,  song_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             music_q;

  logic              note_start;
  logic [NOTE_W-1:0] code;
  logic [HP_W-1:0]   hp;
  logic              tone_restart;
  logic              tone_en;

  // ce has priority in every state: it aborts playback and keeps reloading.
  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    note_start = 1'b0;
    if (ce) begin
      state_d = LOAD;
      song_d  = newFlattenedMCUout;
    end else begin
      case (state_q)
        LOAD: begin
          state_d    = PLAY;
          idx_d      = '0;
          cnt_d      = '0;
          note_start = 1'b1;
        end
        PLAY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              idx_d      = idx_q + IDX_W'(1);
              note_start = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q <= IDLE;
      song_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      music_q <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      music_q <= (state_d == PLAY);
    end
  end

  assign code = song_q[IDX_LAST - idx_q];
  assign hp   = HP_W'(half_period(code, HALF_PERIOD_UNIT));

  // Phase restarts on every note boundary and is held cleared outside PLAY.
  assign tone_restart = (state_d != PLAY) || note_start;
  assign tone_en      = (state_q == PLAY) && (code != '0);

  tone_gen #(
    .HP_W (HP_W)
  ) u_tone_gen (
    .clk           (clk),
    .rst_i         (nreset),
    .restart_i     (tone_restart),
    .en_i          (tone_en),
    .half_period_i (hp),
    .wave_o        (pwm)
  );

  assign maingMusic = music_q;

endmodule

// File: tb/tb_sim_top.sv
// Directed bench for sim_top: per-cycle expectations are queued when a step
// is driven and popped/compared one edge later against both DUT instances.
module tb_sim_top;

  logic        clk;
  logic        nreset;
  logic [39:0] word_a, word_b;
  logic        ce_a,   ce_b;
  logic        pwm_a,  mm_a;
  logic        pwm_b,  mm_b;

  int vectors = 0;
  int fails   = 0;

  typedef struct {
    logic mm;
    logic pwm;
  } exp_t;

  exp_t sb_q[$];

  sim_top dut_a (
    .clk                (clk),
    .nreset             (nreset),
    .newFlattenedMCUout (word_a),
    .ce                 (ce_a),
    .pwm                (pwm_a),
    .maingMusic         (mm_a)
  );

  sim_top #(
    .NOTE_CYCLES      (64),
    .HALF_PERIOD_UNIT (3)
  ) dut_b (
    .clk                (clk),
    .nreset             (nreset),
    .newFlattenedMCUout (word_b),
    .ce                 (ce_b),
    .pwm                (pwm_b),
    .maingMusic         (mm_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pwm at play cycle p: number of completed half-periods within the note, mod 2.
  function automatic logic model_pwm(input logic [39:0] w, input int p, input int ncyc, input int unit);
    int          note, j, h;
    logic [39:0] t;
    logic [3:0]  c;
    note = p / ncyc;
    j    = p % ncyc;
    t    = w >> (36 - 4 * note);
    c    = t[3:0];
    if (c == 4'd0) return 1'b0;
    h = (16 - int'(c)) * unit;
    return ((j / h) % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input int sel, input logic ce_v, input logic [39:0] w);
    if (sel == 0) begin
      ce_a   = ce_v;
      word_a = w;
    end else begin
      ce_b   = ce_v;
      word_b = w;
    end
  endtask

  task automatic cycle_check(input int sel, input logic exp_mm, input logic exp_pwm, input string tag);
    exp_t e;
    logic obs_mm, obs_pwm;
    e.mm  = exp_mm;
    e.pwm = exp_pwm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e       = sb_q.pop_front();
    obs_mm  = (sel == 0) ? mm_a  : mm_b;
    obs_pwm = (sel == 0) ? pwm_a : pwm_b;
    check({tag, "_mm"},  obs_mm,  e.mm);
    check({tag, "_pwm"}, obs_pwm, e.pwm);
  endtask

  // ce high for n cycles; only the last sampled word should become the song.
  task automatic load(input int sel, input logic [39:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      drive(sel, 1'b1, (i == n - 1) ? w : 40'hDEAD_BEEF_A5);
      cycle_check(sel, 1'b0, 1'b0, $sformatf("load%0d", i));
    end
  endtask

  task automatic play(input int sel, input logic [39:0] w, input int ncyc, input int unit, input int n_play);
    drive(sel, 1'b0, 40'h0);
    for (int p = 0; p < n_play; p++)
      cycle_check(sel, 1'b1, model_pwm(w, p, ncyc, unit), $sformatf("play_p%0d", p));
  endtask

  initial begin
    // ce left undriven before reset.
    nreset = 1'b1;
    ce_b   = 1'b0;
    word_b = 40'h0;
    @(posedge clk);
    #1;
    check("reset_mm",  mm_a,  1'b0);
    check("reset_pwm", pwm_a, 1'b0);
    nreset = 1'b0;
    drive(0, 1'b0, 40'h0);
    repeat (4) cycle_check(0, 1'b0, 1'b0, "idle");

    // Reset and ce on the same edge: reset must win.
    nreset = 1'b1;
    drive(0, 1'b1, 40'hFF_FFFF_FFFF);
    cycle_check(0, 1'b0, 1'b0, "rst_vs_ce");
    nreset = 1'b0;
    drive(0, 1'b0, 40'h0);
    repeat (3) cycle_check(0, 1'b0, 1'b0, "rst_won");

    // Basic load and play.
    load(0, 40'h01_2345_6789, 2);
    play(0, 40'h01_2345_6789, 16, 1, 160);
    cycle_check(0, 1'b0, 1'b0, "basic_end");
    repeat (3) cycle_check(0, 1'b0, 1'b0, "basic_idle");

    // High pitch, single-cycle ce pulse.
    load(0, 40'hFF_FFFF_FFFF, 1);
    play(0, 40'hFF_FFFF_FFFF, 16, 1, 160);
    cycle_check(0, 1'b0, 1'b0, "high_end");
    repeat (3) cycle_check(0, 1'b0, 1'b0, "high_idle");

    // Reset mid-song; no resumption afterwards.
    load(0, 40'h01_2345_6789, 2);
    play(0, 40'h01_2345_6789, 16, 1, 100);
    nreset = 1'b1;
    cycle_check(0, 1'b0, 1'b0, "rst_mid");
    nreset = 1'b0;
    repeat (20) cycle_check(0, 1'b0, 1'b0, "no_resume");

    // Reload during PLAY, ce held for several cycles.
    load(0, 40'h01_2345_6789, 2);
    play(0, 40'h01_2345_6789, 16, 1, 40);
    load(0, 40'hF0_0000_0000, 5);
    play(0, 40'hF0_0000_0000, 16, 1, 160);
    cycle_check(0, 1'b0, 1'b0, "reload_end");

    // Slow tones on the second instance: code 8 (H=24), 15 (H=3), 1 (H=45).
    load(1, 40'h8F_0000_0001, 1);
    play(1, 40'h8F_0000_0001, 64, 3, 640);
    cycle_check(1, 1'b0, 1'b0, "slow_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
